// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word type, RAM handshake states, timeout constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Grant cycles allowed before the controller gives up on the RAM.
    localparam int unsigned TIMEOUT_CYCLES = 255;

    // Poison word returned to a requester whose transaction timed out.
    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_timeout.sv
// Grant-cycle watchdog: counts cycles spent waiting on the RAM for one transaction.
// Latency: expired is combinational, high during the grant cycle that completes the budget.
// Backpressure: none; clear wins over enable.
module mem_timeout
    import cpu_types_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // Restart on every new grant, advance once per cycle spent in a grant state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // The counter is about to reach the budget: this grant cycle is the last one allowed.
    assign expired = enable && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cache_mem_ctrl.sv
// Arbitrates icache/dcache requests onto one RAM port with starvation guard and timeout.
// Latency: grant decided in IDLE, earliest completion the following cycle; one IDLE turnaround between transactions.
// Backpressure: requesters hold requests until their wait falls; RAM stalls via ramstate != ACCESS.
module cache_mem_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DGRANT = 2'b01,
        IGRANT = 2'b10,
        TOUT   = 2'b11
    } state_t;

    state_t     state, next_state;
    word_t      lat_addr, lat_data;
    logic       lat_wen;
    logic       owner_d;
    logic [2:0] starve_cnt;
    logic       memerr_q;
    logic       grant_d, grant_i;
    logic       in_grant, access, owner_req;
    logic       tmo_expired;

    assign in_grant  = (state == DGRANT) || (state == IGRANT);
    assign access    = (ramstate == ACCESS);
    assign owner_req = (state == DGRANT) ? (dREN || dWEN) : iREN;
    assign memerr    = memerr_q;

    // IDLE arbitration: icache forced after four straight data grants that it waited through.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (iREN && (starve_cnt >= 3'd4)) begin
                grant_i = 1'b1;
            end else if (dWEN || dREN) begin
                grant_d = 1'b1;
            end else if (iREN) begin
                grant_i = 1'b1;
            end
        end
    end

    mem_timeout u_timeout (
        .clk     (CLK),
        .rst     (nRST),
        .clear   (grant_d || grant_i),
        .enable  (in_grant),
        .expired (tmo_expired)
    );

    // State register.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and all requester/RAM outputs; RAM side driven only from latched values.
    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = DGRANT;
                end else if (grant_i) begin
                    next_state = IGRANT;
                end
            end
            DGRANT, IGRANT: begin
                ramREN   = !lat_wen;
                ramWEN   = lat_wen;
                ramaddr  = lat_addr;
                ramstore = lat_data;
                if (!owner_req) begin
                    // Requester walked away: abandon silently.
                    next_state = IDLE;
                end else if (access) begin
                    next_state = IDLE;
                    if (state == DGRANT) begin
                        dwait = 1'b0;
                        dload = lat_wen ? '0 : ramload;
                    end else begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end else if (tmo_expired) begin
                    next_state = TOUT;
                end
            end
            TOUT: begin
                next_state = IDLE;
                if (owner_d) begin
                    dwait = 1'b0;
                    dload = BAD_WORD;
                end else begin
                    iwait = 1'b0;
                    iload = BAD_WORD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the winning request so the RAM sees stable values for the whole transaction.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_wen  <= 1'b0;
            owner_d  <= 1'b0;
        end else if (grant_d) begin
            lat_addr <= daddr;
            lat_data <= dstore;
            lat_wen  <= dWEN;
            owner_d  <= 1'b1;
        end else if (grant_i) begin
            lat_addr <= iaddr;
            lat_data <= '0;
            lat_wen  <= 1'b0;
            owner_d  <= 1'b0;
        end
    end

    // Count data grants made while the icache was left waiting; any icache grant resets it.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            starve_cnt <= iREN ? starve_cnt + 3'd1 : 3'd0;
        end
    end

    // Sticky error flag, raised as the timeout state is entered and held until reset.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            memerr_q <= 1'b0;
        end else if (in_grant && (next_state == TOUT)) begin
            memerr_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl: vector table plus directed multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_mem_ctrl;

    localparam logic [1:0] RS_FREE = 2'b00;
    localparam logic [1:0] RS_BUSY = 2'b01;
    localparam logic [1:0] RS_ACC  = 2'b10;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fail   = 0;

    cache_mem_ctrl dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ir, dr, dw;
        logic [31:0] ia, da, ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_il, e_dl, e_ra, e_rst;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic dr, input logic dw,
        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
        input logic [1:0] rs, input logic [31:0] rl,
        input logic eiw, input logic edw, input logic er, input logic ew,
        input logic [31:0] eil, input logic [31:0] edl,
        input logic [31:0] era, input logic [31:0] erst);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw;
        v.ia = ia; v.da = da; v.ds = ds;
        v.rs = rs; v.rl = rl;
        v.e_iw = eiw; v.e_dw = edw; v.e_ren = er; v.e_wen = ew;
        v.e_il = eil; v.e_dl = edl; v.e_ra = era; v.e_rst = erst;
        return v;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic ir, input logic dr, input logic dw,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                          input logic [1:0] rs, input logic [31:0] rl);
        iREN = ir; dREN = dr; dWEN = dw;
        iaddr = ia; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt[14];
    int   bad;

    initial begin
        // Cycle-by-cycle table, starting from IDLE just after reset release.
        vt[0]  = mk(0,0,0, 0,0,0,               RS_FREE, 0,        1,1,0,0, 0,0,0,0);
        vt[1]  = mk(0,1,0, 0,32'h40,0,          RS_FREE, 32'h1234, 1,1,0,0, 0,0,0,0);
        vt[2]  = mk(0,1,0, 0,32'h40,0,          RS_BUSY, 32'h1234, 1,1,1,0, 0,0,32'h40,0);
        vt[3]  = mk(0,1,0, 0,32'h40,0,          RS_BUSY, 32'h1234, 1,1,1,0, 0,0,32'h40,0);
        vt[4]  = mk(0,1,0, 0,32'h40,0,          RS_ACC,  32'h1234, 1,0,1,0, 0,32'h1234,32'h40,0);
        vt[5]  = mk(0,0,0, 0,0,0,               RS_FREE, 0,        1,1,0,0, 0,0,0,0);
        vt[6]  = mk(1,0,1, 32'h100,32'h80,32'hDEAD, RS_FREE, 0,        1,1,0,0, 0,0,0,0);
        vt[7]  = mk(1,0,1, 32'h100,32'h80,32'hDEAD, RS_ACC,  32'h9999, 1,0,0,1, 0,0,32'h80,32'hDEAD);
        vt[8]  = mk(1,0,0, 32'h100,0,0,         RS_ACC,  32'h5555, 1,1,0,0, 0,0,0,0);
        vt[9]  = mk(1,0,0, 32'h100,0,0,         RS_ACC,  32'h5555, 0,1,1,0, 32'h5555,0,32'h100,0);
        vt[10] = mk(0,0,0, 0,0,0,               RS_FREE, 0,        1,1,0,0, 0,0,0,0);
        vt[11] = mk(0,1,1, 0,32'hC,32'h77,      RS_FREE, 0,        1,1,0,0, 0,0,0,0);
        vt[12] = mk(0,1,1, 0,32'hC,32'h77,      RS_ACC,  32'hAAAA, 1,0,0,1, 0,0,32'hC,32'h77);
        vt[13] = mk(0,0,0, 0,0,0,               RS_FREE, 0,        1,1,0,0, 0,0,0,0);

        // Reset values while reset is held.
        nRST = 1'b1;
        set_in(0,0,0, 0,0,0, RS_FREE, 0);
        @(negedge CLK);
        chk1("rst_iwait", iwait, 1'b1);
        chk1("rst_dwait", dwait, 1'b1);
        chk1("rst_ramREN", ramREN, 1'b0);
        chk1("rst_ramWEN", ramWEN, 1'b0);
        chk1("rst_memerr", memerr, 1'b0);
        chk32("rst_iload", iload, 32'h0);
        chk32("rst_dload", dload, 32'h0);
        nRST = 1'b0;
        tick();

        foreach (vt[i]) begin
            set_in(vt[i].ir, vt[i].dr, vt[i].dw, vt[i].ia, vt[i].da, vt[i].ds, vt[i].rs, vt[i].rl);
            @(negedge CLK);
            chk1 ($sformatf("v%0d_iwait", i),    iwait,    vt[i].e_iw);
            chk1 ($sformatf("v%0d_dwait", i),    dwait,    vt[i].e_dw);
            chk1 ($sformatf("v%0d_ramREN", i),   ramREN,   vt[i].e_ren);
            chk1 ($sformatf("v%0d_ramWEN", i),   ramWEN,   vt[i].e_wen);
            chk32($sformatf("v%0d_iload", i),    iload,    vt[i].e_il);
            chk32($sformatf("v%0d_dload", i),    dload,    vt[i].e_dl);
            chk32($sformatf("v%0d_ramaddr", i),  ramaddr,  vt[i].e_ra);
            chk32($sformatf("v%0d_ramstore", i), ramstore, vt[i].e_rst);
            tick();
        end

        // Abort: dREN dropped after two grant cycles; ACCESS in the drop cycle must not complete it.
        set_in(0,1,0, 0,32'h500,0, RS_BUSY, 32'h1111);
        tick();
        @(negedge CLK);
        chk1("abort_g1_ramREN", ramREN, 1'b1);
        tick();
        @(negedge CLK);
        chk1("abort_g2_ramREN", ramREN, 1'b1);
        tick();
        set_in(0,0,0, 0,0,0, RS_ACC, 32'h1111);
        @(negedge CLK);
        chk1("abort_drop_dwait", dwait, 1'b1);
        tick();
        @(negedge CLK);
        chk1("abort_next_ramREN", ramREN, 1'b0);
        chk1("abort_next_dwait", dwait, 1'b1);
        tick();

        // Starvation: iREN held, data requests back to back; fifth decision goes to the icache.
        set_in(1,1,0, 32'h200,32'h600,0, RS_ACC, 32'h7777);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (iwait !== 1'b1 || dwait !== 1'b1) bad++;
            tick();
            @(negedge CLK);
            if (dwait !== 1'b0 || iwait !== 1'b1 || ramaddr !== 32'h600) bad++;
            tick();
        end
        chk32("starve_data_grants", 32'(bad), 32'd0);
        @(negedge CLK);
        chk1("starve_idle_iwait", iwait, 1'b1);
        tick();
        @(negedge CLK);
        chk1("starve_iwait", iwait, 1'b0);
        chk1("starve_dwait", dwait, 1'b1);
        chk32("starve_ramaddr", ramaddr, 32'h200);
        chk32("starve_iload", iload, 32'h7777);
        set_in(0,0,0, 0,0,0, RS_FREE, 0);
        tick();
        tick();

        // Timeout: RAM stuck BUSY for a data read.
        set_in(0,1,0, 0,32'h300,0, RS_BUSY, 32'h4242);
        tick();
        bad = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge CLK);
            if (dwait !== 1'b1 || ramREN !== 1'b1) bad++;
            if (k == 255) chk1("tout_memerr_before", memerr, 1'b0);
            tick();
        end
        chk32("tout_wait_held", 32'(bad), 32'd0);
        @(negedge CLK);
        chk1("tout_dwait", dwait, 1'b0);
        chk32("tout_dload", dload, 32'hBAD1BAD1);
        chk1("tout_ramREN", ramREN, 1'b0);
        chk1("tout_memerr", memerr, 1'b1);
        chk1("tout_iwait", iwait, 1'b1);
        tick();
        set_in(0,0,0, 0,0,0, RS_FREE, 0);
        @(negedge CLK);
        chk1("tout_after_dwait", dwait, 1'b1);
        chk32("tout_after_dload", dload, 32'h0);
        tick();
        tick();
        tick();
        @(negedge CLK);
        chk1("tout_memerr_sticky", memerr, 1'b1);
        tick();

        // Reset pulsed during IGRANT: outputs at reset values at once, IDLE after release.
        set_in(1,0,0, 32'h400,0,0, RS_BUSY, 32'h8888);
        tick();
        @(negedge CLK);
        chk1("rstmid_ramREN_before", ramREN, 1'b1);
        chk32("rstmid_ramaddr_before", ramaddr, 32'h400);
        tick();
        ramstate = RS_ACC;
        nRST = 1'b1;
        #1;
        chk1("rstmid_iwait", iwait, 1'b1);
        chk1("rstmid_dwait", dwait, 1'b1);
        chk1("rstmid_ramREN", ramREN, 1'b0);
        chk32("rstmid_iload", iload, 32'h0);
        chk1("rstmid_memerr", memerr, 1'b0);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk1("rstrel_idle_iwait", iwait, 1'b1);
        chk1("rstrel_idle_ramREN", ramREN, 1'b0);
        tick();
        @(negedge CLK);
        chk1("rstrel_grant_iwait", iwait, 1'b0);
        chk32("rstrel_grant_iload", iload, 32'h8888);
        set_in(0,0,0, 0,0,0, RS_FREE, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
